pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default XLEN (32): width of the datapath payload (pc, operands, immediate, register indices).
REQ-002 Parameter CTRL_W, default 16: width of the control payload (Branch, MemtoReg, MemWrite, ALUSrc, PCSrc, RegWrite, ALUOp, Type_Select, …).
REQ-003 Parameter CNT_W, default 16: width of each performance counter.
REQ-004 Port: clock, in, 1, sole clock; all state changes on the rising edge.
REQ-005 Port: reset, in, 1, synchronous, active-high.
REQ-006 Port: flush, in, 1, discard all held beats (branch taken or exception).
REQ-007 Port: in_valid, in, 1, upstream beat present.
REQ-008 Port: in_ready, out, 1, stage accepts a beat this cycle.
REQ-009 Port: in_data, in, DATA_W, upstream datapath payload.
REQ-010 Port: in_ctrl, in, CTRL_W, upstream control payload.
REQ-011 Port: out_valid, out, 1, beat presented downstream.
REQ-012 Port: out_ready, in, 1, downstream accepts the beat.
REQ-013 Port: out_data, out, DATA_W, downstream datapath payload.
REQ-014 Port: out_ctrl, out, CTRL_W, downstream control payload.
REQ-015 Port: stall_cnt, out, CNT_W, saturating count of cycles with in_valid=1 and in_ready=0.
REQ-016 Port: bubble_cnt, out, CNT_W, saturating count of cycles with out_ready=1 and out_valid=0.

Function
REQ-017 Push = in_valid & in_ready; pop = out_valid & out_ready; a beat transfers only on a handshake.
REQ-018 Storage: main register (drives out_*) plus one skid register; FSM states EMPTY, HALF (main only), FULL (main + skid).
REQ-019 in_ready SHALL be 1 in EMPTY and HALF and 0 in FULL, decoded from registered state only (no combinational out_ready→in_ready path).
REQ-020 out_valid SHALL be 1 in HALF and FULL, 0 in EMPTY.
REQ-021 Latency: a beat pushed into EMPTY appears on out_* the next cycle.
REQ-022 EMPTY: push → HALF (beat to main); otherwise remain.
REQ-023 HALF: push & pop → HALF (main takes new beat); push & !pop → FULL (new beat to skid); pop & !push → EMPTY; neither → remain.
REQ-024 FULL: pop → HALF (skid moves to main, skid freed); no push is possible; !pop → remain.
REQ-025 Ordering SHALL be strict FIFO; no beat is duplicated or dropped except by flush or reset.
REQ-026 flush=1: next state EMPTY regardless of push/pop; a beat offered in the same cycle is dropped; flush has priority over push and pop.
REQ-027 out_ctrl SHALL be all-zero whenever out_valid=0, so bubbles never carry RegWrite or MemWrite; out_data is don't-care when out_valid=0.
REQ-028 stall_cnt and bubble_cnt increment by 1 per qualifying cycle, saturate at 2^CNT_W−1, and never wrap.
REQ-029 Counters SHALL not count the cycle in which flush=1.

Reset
REQ-030 reset=1 at a clock edge: state EMPTY, main and skid registers 0, stall_cnt=0, bubble_cnt=0; reset has priority over flush and handshakes.
REQ-031 Immediately after reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
REQ-032 Reset asserted mid-operation (HALF or FULL) discards all held beats identically to the initial reset.

Structure
REQ-033 FSM state encoding (EMPTY, HALF, FULL) and the XLEN default SHALL live in the shared package; no local redefinition.
REQ-034 Both counters SHALL be instances of one sub-module, pipe_sat_counter (parameter CNT_W; inputs clock, reset, inc; output count).
REQ-035 The existing per-stage ID/EX/MEM/WB registers SHALL be replaceable by instances of this block, with ctrl and data concatenated by the instantiating parent.

Verification
REQ-036 Reset, then push data=0x00000010, ctrl=0x0021 with out_ready=1 → next cycle out_valid=1, out_data=0x10, out_ctrl=0x0021; one cycle later out_valid=0, out_ctrl=0.
REQ-037 out_ready=0, push 0xA then 0xB → FULL, in_ready=0; hold in_valid=1 for 3 cycles → stall_cnt=3; release out_ready → 0xA, 0xB delivered in order, no loss.
REQ-038 Continuous push 0x1..0x8 with out_ready=1 → one beat per cycle, throughput 1, stall_cnt=0.
REQ-039 FULL with 0xC, 0xD, assert flush while in_valid=1 (0xE) → next cycle EMPTY, out_valid=0, out_ctrl=0; 0xC, 0xD, 0xE never appear.
REQ-040 CNT_W=4, out_ready=1, in_valid=0 for 20 cycles → bubble_cnt=15, no wrap.
REQ-041 Assert reset while FULL with flush=1 → next cycle all outputs and counters 0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg
//   Shared definitions for the skid-buffered pipeline stage: the default
//   datapath width and the occupancy state encoding used by the stage FSM.
package pipe_stage_skid_pkg;

    localparam int XLEN = 32;

    // Occupancy of the stage: nothing held, main register only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage : pipe_stage_skid_pkg

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
//   Saturating up-counter used for stage performance statistics.
//   Ports:
//     clock - rising-edge clock
//     reset - synchronous, active-high; clears count
//     inc   - add one this cycle (ignored once count is all-ones)
//     count - current value, sticks at 2^CNT_W-1
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   One pipeline stage with a valid/ready handshake and a single skid
//   register, so in_ready depends only on registered state. Intended as a
//   drop-in for the ID/EX/MEM/WB stage registers; the parent concatenates
//   its control and data fields into in_ctrl / in_data.
//   Ports:
//     clock, reset           - rising-edge clock, synchronous active-high reset
//     flush                  - discard every held beat and any beat offered now
//     in_valid/in_ready      - upstream handshake
//     in_data/in_ctrl        - upstream payload
//     out_valid/out_ready    - downstream handshake
//     out_data/out_ctrl      - downstream payload (out_ctrl forced to 0 on bubbles)
//     stall_cnt              - saturating count of in_valid & !in_ready cycles
//     bubble_cnt             - saturating count of out_ready & !out_valid cycles
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    skid_state_e       state, state_next;
    logic [DATA_W-1:0] main_data, main_data_next;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_next;
    logic [DATA_W-1:0] skid_data, skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_next;
    logic              push, pop;

    // Handshake signals decode from registered state only: no path from
    // out_ready to in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data  = main_data;
    // Bubbles must never carry RegWrite/MemWrite downstream.
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    // NOTE: the payload registers are reset too, because out_data must read
    // zero straight after reset rather than whatever was last latched.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_next;
            main_data <= main_data_next;
            main_ctrl <= main_ctrl_next;
            skid_data <= skid_data_next;
            skid_ctrl <= skid_ctrl_next;
        end
    end

    // NOTE: every output of this block is given a hold value first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        main_data_next = main_data;
        main_ctrl_next = main_ctrl;
        skid_data_next = skid_data;
        skid_ctrl_next = skid_ctrl;

        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_next     = HALF;
                    main_data_next = in_data;
                    main_ctrl_next = in_ctrl;
                end
            end
            HALF: begin
                if (push && pop) begin
                    main_data_next = in_data;
                    main_ctrl_next = in_ctrl;
                end else if (push) begin
                    state_next     = FULL;
                    skid_data_next = in_data;
                    skid_ctrl_next = in_ctrl;
                end else if (pop) begin
                    state_next     = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_next     = HALF;
                    main_data_next = skid_data;
                    main_ctrl_next = skid_ctrl;
                end
            end
            default: state_next = EMPTY;
        endcase

        // Flush wins over any handshake; stale payload is hidden by out_valid.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (in_valid & ~in_ready & ~flush),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (out_ready & ~out_valid & ~flush),
        .count (bubble_cnt)
    );

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Directed scenarios plus randomized traffic for pipe_stage_skid, compared
//   every cycle against a queue-based model of a two-entry FIFO stage.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    beat_t m_q[$];
    int    m_stall  = 0;
    int    m_bubble = 0;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
    endtask

    // One clock: compare DUT to model mid-cycle, then advance the model with
    // the inputs that the DUT sees at the rising edge.
    task automatic cycle();
        bit m_push, m_pop;
        beat_t b;
        @(negedge clock);
        if (!reset) begin
            check("m_out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check("m_in_ready", 64'(in_ready), 64'(m_q.size() < 2));
            check("m_out_ctrl", 64'(out_ctrl), (m_q.size() > 0) ? 64'(m_q[0].ctrl) : 64'd0);
            if (m_q.size() > 0) check("m_out_data", 64'(out_data), 64'(m_q[0].data));
            check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
            check("m_bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
        end
        @(posedge clock);
        if (reset) begin
            m_q.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            m_push = in_valid && (m_q.size() < 2);
            m_pop  = out_ready && (m_q.size() > 0);
            if (!flush) begin
                if (in_valid && m_q.size() == 2 && m_stall < CNT_MAX) m_stall++;
                if (out_ready && m_q.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
            end
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    b.data = in_data;
                    b.ctrl = in_ctrl;
                    m_q.push_back(b);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state and single-beat latency.
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h10, 16'h0021, 1'b1, 1'b0, 1'b0);
        cycle();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data", 64'(out_data), 64'h10);
        check("lat_out_ctrl", 64'(out_ctrl), 64'h0021);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("lat_drain_valid", 64'(out_valid), 64'd0);
        check("lat_drain_ctrl", 64'(out_ctrl), 64'd0);

        // Fill, stall three cycles, then drain in order.
        do_reset();
        drive(1'b1, 32'hA, 16'h1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'hB, 16'h2, 1'b0, 1'b0, 1'b0);
        cycle();
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'hF, 16'h3, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("stall_3", 64'(stall_cnt), 64'd3);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_a", 64'(out_data), 64'hA);
        cycle();
        check("drain_b", 64'(out_data), 64'hB);
        check("drain_b_valid", 64'(out_valid), 64'd1);
        cycle();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Back-to-back streaming at full throughput.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0, 1'b0);
            cycle();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // Flush while full with a beat offered.
        do_reset();
        drive(1'b1, 32'hC, 16'h4, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'hD, 16'h5, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'hE, 16'h6, 1'b0, 1'b1, 1'b0);
        cycle();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("flush_no_ghost", 64'(out_valid), 64'd0);
        end

        // Bubble counter saturation.
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (20) cycle();
        check("bubble_sat", 64'(bubble_cnt), 64'(CNT_MAX));

        // Reset with flush while full, counters non-zero.
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h11, 16'h7, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("pre_rst_stall", 64'(stall_cnt), 64'd1);
        check("pre_rst_bubble", 64'(bubble_cnt), 64'd1);
        drive(1'b1, 32'h12, 16'h8, 1'b1, 1'b1, 1'b1);
        cycle();
        reset = 1'b0;
        flush = 1'b0;
        check("rst_full_valid", 64'(out_valid), 64'd0);
        check("rst_full_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_full_data", 64'(out_data), 64'd0);
        check("rst_full_ready", 64'(in_ready), 64'd1);
        check("rst_full_stall", 64'(stall_cnt), 64'd0);
        check("rst_full_bubble", 64'(bubble_cnt), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), CTRL_W'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 127) == 0));
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_stage_skid
